// File: rtl/rs_issue_sched_pkg.sv
// rtl/rs_issue_sched_pkg.sv - shared types and constants for the RS issue scheduler
package rs_issue_sched_pkg;

    localparam int NUM_RS   = 5;
    localparam int NUM_FU   = 4;
    localparam int MULT_LAT = 4;
    localparam int RS_IDX_W = $clog2(NUM_RS);

    typedef enum logic [1:0] {
        ALU   = 2'd0,
        LOAD  = 2'd1,
        STORE = 2'd2,
        MULT  = 2'd3
    } fu_class_e;

    typedef enum logic [1:0] {
        LANE_IDLE = 2'd0,
        LANE_HOLD = 2'd1,
        LANE_BUSY = 2'd2
    } lane_state_e;

    typedef struct packed {
        logic                valid;
        logic [RS_IDX_W-1:0] idx;
    } issue_lane_t;

    // Round-robin successor of an entry index, wrapping the last entry to 0.
    function automatic int next_ptr(input int idx, input int num_rs);
        return (idx == num_rs - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rs_issue_sched_if.sv
// rtl/rs_issue_sched_if.sv - RS/FU-facing signal bundle of the issue scheduler
interface rs_issue_sched_if #(
    parameter int NUM_RS   = rs_issue_sched_pkg::NUM_RS,
    parameter int NUM_FU   = rs_issue_sched_pkg::NUM_FU,
    parameter int RS_IDX_W = $clog2(NUM_RS)
);
    logic [NUM_RS-1:0]                entry_ready;
    logic [NUM_RS-1:0][1:0]           entry_fu;
    logic                             squash;
    logic [NUM_FU-1:0]                fu_ready;
    logic [NUM_FU-1:0]                issue_valid;
    logic [NUM_FU-1:0][RS_IDX_W-1:0]  issue_idx;
    logic [NUM_RS-1:0]                issue_grant;
    logic                             mult_busy;

    modport master (
        input  entry_ready, entry_fu, squash, fu_ready,
        output issue_valid, issue_idx, issue_grant, mult_busy
    );

    modport slave (
        output entry_ready, entry_fu, squash, fu_ready,
        input  issue_valid, issue_idx, issue_grant, mult_busy
    );
endinterface

// File: rtl/rs_issue_sched_rr_pick.sv
// rtl/rs_issue_sched_rr_pick.sv - round-robin finder: first set request at or after ptr
module rs_issue_sched_rr_pick #(
    parameter int NUM_RS = 5,
    parameter int IDX_W  = $clog2(NUM_RS)
) (
    input  logic [NUM_RS-1:0] req,
    input  logic [IDX_W-1:0]  ptr,
    output logic              found,
    output logic [IDX_W-1:0]  idx
);
    int               pos;
    logic [IDX_W-1:0] pos_idx;

    always_comb begin
        found   = 1'b0;
        idx     = '0;
        pos     = 0;
        pos_idx = '0;
        for (int k = 0; k < NUM_RS; k++) begin
            pos     = (int'(ptr) + k) % NUM_RS;
            pos_idx = IDX_W'(pos);
            if (!found && req[pos_idx]) begin
                found = 1'b1;
                idx   = pos_idx;
            end
        end
    end
endmodule

// File: rtl/rs_issue_sched.sv
// rtl/rs_issue_sched.sv - per-class round-robin issue from RS entries into FU issue lanes
module rs_issue_sched #(
    parameter int NUM_RS   = rs_issue_sched_pkg::NUM_RS,
    parameter int NUM_FU   = rs_issue_sched_pkg::NUM_FU,
    parameter int MULT_LAT = rs_issue_sched_pkg::MULT_LAT
) (
    input  logic             clock,
    input  logic             reset_n,
    rs_issue_sched_if.master bus
);
    import rs_issue_sched_pkg::*;

    localparam int IDX_W     = $clog2(NUM_RS);
    localparam int CNT_W     = $clog2(MULT_LAT + 1);
    localparam int MULT_LANE = int'(MULT);

    lane_state_e                  state_q [NUM_FU];
    lane_state_e                  state_d [NUM_FU];
    logic [IDX_W-1:0]             idx_q   [NUM_FU];
    logic [IDX_W-1:0]             idx_d   [NUM_FU];
    logic [IDX_W-1:0]             ptr_q   [NUM_FU];
    logic [IDX_W-1:0]             ptr_d   [NUM_FU];
    logic [IDX_W-1:0]             pick_idx[NUM_FU];
    logic [CNT_W-1:0]             cnt_q, cnt_d;

    logic [NUM_FU-1:0]              transfer;
    logic [NUM_FU-1:0]              can_load;
    logic [NUM_FU-1:0]              found;
    logic [NUM_FU-1:0]              grant;
    logic [NUM_RS-1:0]              held;
    logic [NUM_FU-1:0][NUM_RS-1:0]  req;
    logic [NUM_RS-1:0]              grant_vec;
    logic [NUM_FU-1:0]              lane_valid;
    logic [NUM_FU-1:0][IDX_W-1:0]   lane_idx;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int f = 0; f < NUM_FU; f++) begin
                state_q[f] <= LANE_IDLE;
                idx_q[f]   <= '0;
                ptr_q[f]   <= '0;
            end
            cnt_q <= '0;
        end else begin
            for (int f = 0; f < NUM_FU; f++) begin
                state_q[f] <= state_d[f];
                idx_q[f]   <= idx_d[f];
                ptr_q[f]   <= ptr_d[f];
            end
            cnt_q <= cnt_d;
        end
    end

    // Held entries stay masked even while transferring, so the RS has a cycle to drop ready.
    always_comb begin
        transfer = '0;
        can_load = '0;
        held     = '0;
        req      = '0;
        for (int f = 0; f < NUM_FU; f++) begin
            transfer[f] = (state_q[f] == LANE_HOLD) && bus.fu_ready[f];
            if (f == MULT_LANE && MULT_LAT > 1)
                can_load[f] = !bus.squash && (state_q[f] == LANE_IDLE);
            else
                can_load[f] = !bus.squash && ((state_q[f] == LANE_IDLE) || transfer[f]);
            if (state_q[f] == LANE_HOLD)
                held[idx_q[f]] = 1'b1;
        end
        for (int f = 0; f < NUM_FU; f++) begin
            for (int i = 0; i < NUM_RS; i++) begin
                req[f][i] = bus.entry_ready[i] && (bus.entry_fu[i] == 2'(f)) && !held[i];
            end
        end
    end

    for (genvar g = 0; g < NUM_FU; g++) begin : g_pick
        rs_issue_sched_rr_pick #(
            .NUM_RS (NUM_RS),
            .IDX_W  (IDX_W)
        ) u_pick (
            .req   (req[g]),
            .ptr   (ptr_q[g]),
            .found (found[g]),
            .idx   (pick_idx[g])
        );
    end

    always_comb begin
        grant     = '0;
        grant_vec = '0;
        cnt_d     = cnt_q;
        for (int f = 0; f < NUM_FU; f++) begin
            state_d[f] = state_q[f];
            idx_d[f]   = idx_q[f];
            ptr_d[f]   = ptr_q[f];
            grant[f]   = can_load[f] && found[f] && reset_n;
            if (grant[f]) begin
                grant_vec[pick_idx[f]] = 1'b1;
                state_d[f] = LANE_HOLD;
                idx_d[f]   = pick_idx[f];
                ptr_d[f]   = IDX_W'(next_ptr(int'(pick_idx[f]), NUM_RS));
            end else begin
                unique case (state_q[f])
                    LANE_IDLE: state_d[f] = LANE_IDLE;
                    LANE_HOLD: begin
                        // Squash wins over a coincident transfer: the op is dropped.
                        if (bus.squash) begin
                            state_d[f] = LANE_IDLE;
                        end else if (transfer[f]) begin
                            if (f == MULT_LANE && MULT_LAT > 1) begin
                                state_d[f] = LANE_BUSY;
                                cnt_d      = CNT_W'(MULT_LAT - 1);
                            end else begin
                                state_d[f] = LANE_IDLE;
                            end
                        end
                    end
                    LANE_BUSY: begin
                        cnt_d = cnt_q - 1'b1;
                        if (cnt_q == CNT_W'(1))
                            state_d[f] = LANE_IDLE;
                    end
                    default: state_d[f] = LANE_IDLE;
                endcase
            end
        end
    end

    always_comb begin
        lane_valid = '0;
        lane_idx   = '0;
        for (int f = 0; f < NUM_FU; f++) begin
            lane_valid[f] = (state_q[f] == LANE_HOLD);
            lane_idx[f]   = idx_q[f];
        end
    end

    assign bus.issue_valid = lane_valid;
    assign bus.issue_idx   = lane_idx;
    assign bus.issue_grant = grant_vec;
    assign bus.mult_busy   = (state_q[MULT_LANE] == LANE_BUSY);
endmodule

// File: tb/tb_rs_issue_sched.sv
// tb/tb_rs_issue_sched.sv - scoreboard bench for rs_issue_sched
module tb_rs_issue_sched;
    import rs_issue_sched_pkg::*;

    logic clock = 1'b0;
    logic reset_n;
    int   cyc = 0;
    int   n_total = 0;
    int   n_pass = 0;
    int   c0, c1;

    typedef struct { int cyc; logic [4:0] grant; } grant_exp_t;
    typedef struct { int cyc; int lane; int idx; } xfer_exp_t;
    grant_exp_t gq[$];
    xfer_exp_t  xq[$];
    grant_exp_t ge;
    xfer_exp_t  xe;

    rs_issue_sched_if bus ();

    rs_issue_sched dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic exp_grant(input int c, input logic [4:0] g);
        grant_exp_t e;
        e.cyc = c;
        e.grant = g;
        gq.push_back(e);
    endtask

    task automatic exp_xfer(input int c, input int lane, input int idx);
        xfer_exp_t e;
        e.cyc = c;
        e.lane = lane;
        e.idx = idx;
        xq.push_back(e);
    endtask

    // Monitor: every grant and every lane transfer consumes one expectation.
    always @(negedge clock) begin
        if (bus.issue_grant != '0) begin
            n_total++;
            if (gq.size() == 0) begin
                $display("FAIL grant: got %b at cycle %0d, none expected", bus.issue_grant, cyc);
            end else begin
                ge = gq.pop_front();
                if (ge.cyc == cyc && ge.grant == bus.issue_grant) n_pass++;
                else $display("FAIL grant: got %b at cycle %0d, expected %b at cycle %0d",
                              bus.issue_grant, cyc, ge.grant, ge.cyc);
            end
        end
        for (int f = 0; f < 4; f++) begin
            if (bus.issue_valid[f] && bus.fu_ready[f]) begin
                n_total++;
                if (xq.size() == 0) begin
                    $display("FAIL xfer: lane %0d idx %0d at cycle %0d, none expected",
                             f, bus.issue_idx[f], cyc);
                end else begin
                    xe = xq.pop_front();
                    if (xe.cyc == cyc && xe.lane == f && xe.idx == int'(bus.issue_idx[f])) n_pass++;
                    else $display("FAIL xfer: got lane %0d idx %0d at cycle %0d, expected lane %0d idx %0d at cycle %0d",
                                  f, bus.issue_idx[f], cyc, xe.lane, xe.idx, xe.cyc);
                end
            end
        end
    end

    initial begin
        reset_n         = 1'b0;
        bus.entry_ready = '0;
        bus.entry_fu    = '0;
        bus.squash      = 1'b0;
        bus.fu_ready    = '0;
        repeat (2) tick();
        bus.entry_ready = 5'b00001;
        #3;
        check("rst_grant", 32'(bus.issue_grant), 32'(0));
        check("rst_valid", 32'(bus.issue_valid), 32'(0));
        check("rst_idx",   32'(bus.issue_idx),   32'(0));
        check("rst_busy",  32'(bus.mult_busy),   32'(0));
        tick();
        bus.entry_ready = '0;
        reset_n = 1'b1;

        // Single ALU entry: grant now, valid next cycle.
        tick(); c0 = cyc;
        bus.entry_fu[2] = ALU; bus.entry_ready = 5'b00100; bus.fu_ready = 4'b1111;
        exp_grant(c0, 5'b00100); exp_xfer(c0 + 1, 0, 2);
        #3 check("t1_valid_c0", 32'(bus.issue_valid), 32'(0));
        tick(); bus.entry_ready = '0;
        #3 check("t1_valid_c1", 32'(bus.issue_valid), 32'(4'b0001));
        check("t1_idx_c1", 32'(bus.issue_idx[0]), 32'(2));
        tick();
        #3 check("t1_valid_c2", 32'(bus.issue_valid), 32'(0));

        // Two ALU entries held ready: ptr starts at 3, so 3,1,3,1 back-to-back.
        tick(); c0 = cyc;
        bus.entry_fu[1] = ALU; bus.entry_fu[3] = ALU; bus.entry_ready = 5'b01010;
        exp_grant(c0, 5'b01000);     exp_grant(c0 + 1, 5'b00010);
        exp_grant(c0 + 2, 5'b01000); exp_grant(c0 + 3, 5'b00010);
        exp_xfer(c0 + 1, 0, 3); exp_xfer(c0 + 2, 0, 1);
        exp_xfer(c0 + 3, 0, 3); exp_xfer(c0 + 4, 0, 1);
        repeat (4) tick();
        bus.entry_ready = '0;
        #3 check("t2_valid_c4", 32'(bus.issue_valid[0]), 32'(1));
        repeat (2) tick();

        // LOAD stall: entry 4 held three cycles, entry 0 granted on the release cycle.
        tick(); c0 = cyc;
        bus.entry_fu[4] = LOAD; bus.entry_fu[0] = LOAD;
        bus.entry_ready = 5'b10000; bus.fu_ready = 4'b1101;
        exp_grant(c0, 5'b10000); exp_xfer(c0 + 4, 1, 4);
        exp_grant(c0 + 4, 5'b00001); exp_xfer(c0 + 5, 1, 0);
        tick(); bus.entry_ready = 5'b00001;
        for (int k = 1; k <= 3; k++) begin
            #3 check($sformatf("t3_idx_c%0d", k), 32'(bus.issue_idx[1]), 32'(4));
            check($sformatf("t3_valid_c%0d", k), 32'(bus.issue_valid[1]), 32'(1));
            tick();
        end
        bus.fu_ready = 4'b1111;
        tick(); bus.entry_ready = '0;
        repeat (2) tick();

        // MULT occupancy with MULT_LAT=4.
        tick(); c0 = cyc;
        bus.entry_fu[0] = MULT; bus.entry_fu[1] = MULT; bus.entry_ready = 5'b00011;
        exp_grant(c0, 5'b00001); exp_xfer(c0 + 1, 3, 0);
        exp_grant(c0 + 5, 5'b00010); exp_xfer(c0 + 6, 3, 1);
        tick(); bus.entry_ready = 5'b00010;
        #3 check("t4_busy_c1", 32'(bus.mult_busy), 32'(0));
        tick();
        #3 check("t4_busy_c2", 32'(bus.mult_busy), 32'(1));
        repeat (2) tick();
        #3 check("t4_busy_c4", 32'(bus.mult_busy), 32'(1));
        tick();
        #3 check("t4_busy_c5", 32'(bus.mult_busy), 32'(0));
        tick(); bus.entry_ready = '0;
        #3 check("t4_valid_c6", 32'(bus.issue_valid[3]), 32'(1));
        tick();
        #3 check("t4_busy_c7", 32'(bus.mult_busy), 32'(1));
        repeat (3) tick();
        #3 check("t4_busy_c10", 32'(bus.mult_busy), 32'(0));

        // Squash with ALU and STORE lanes holding; ALU pointer must survive (3 -> entry 4).
        tick(); c0 = cyc;
        bus.entry_fu[2] = ALU; bus.entry_fu[3] = STORE;
        bus.entry_ready = 5'b01100; bus.fu_ready = 4'b0000;
        exp_grant(c0, 5'b01100);
        exp_grant(c0 + 3, 5'b10000); exp_xfer(c0 + 4, 0, 4);
        exp_grant(c0 + 4, 5'b00010); exp_xfer(c0 + 5, 0, 1);
        tick(); bus.entry_ready = '0;
        tick();
        bus.squash = 1'b1; bus.entry_fu[1] = ALU; bus.entry_fu[4] = ALU;
        bus.entry_ready = 5'b10010;
        #3 check("t5_grant_squash", 32'(bus.issue_grant), 32'(0));
        check("t5_valid_squash", 32'(bus.issue_valid), 32'(4'b0101));
        tick(); bus.squash = 1'b0; bus.fu_ready = 4'b1111;
        #3 check("t5_valid_after", 32'(bus.issue_valid), 32'(0));
        tick(); bus.entry_ready = 5'b00010;
        tick(); bus.entry_ready = '0;
        repeat (2) tick();

        // Reset asserted between edges while MULT is busy.
        tick(); c0 = cyc;
        bus.entry_fu[2] = MULT; bus.entry_ready = 5'b00100;
        exp_grant(c0, 5'b00100); exp_xfer(c0 + 1, 3, 2);
        tick(); bus.entry_ready = '0;
        tick();
        bus.entry_fu[1] = MULT; bus.entry_fu[3] = MULT; bus.entry_ready = 5'b01010;
        #3 check("t6_busy", 32'(bus.mult_busy), 32'(1));
        check("t6_grant_busy", 32'(bus.issue_grant), 32'(0));
        #2 reset_n = 1'b0;
        #1 check("t6_rst_busy", 32'(bus.mult_busy), 32'(0));
        check("t6_rst_valid", 32'(bus.issue_valid), 32'(0));
        check("t6_rst_grant", 32'(bus.issue_grant), 32'(0));
        tick(); reset_n = 1'b1; c1 = cyc;
        exp_grant(c1, 5'b00010); exp_xfer(c1 + 1, 3, 1);
        tick(); bus.entry_ready = '0;
        repeat (6) tick();

        check("grant_queue_empty", 32'(gq.size()), 32'(0));
        check("xfer_queue_empty", 32'(xq.size()), 32'(0));
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
